uart_frame_rx: RTL
==================

Name: uart_frame_rx

Overview:
UART receiver plus frame loader, the inbound counterpart of the camera-to-PC byte transmitter. It deserialises 8N1 bytes from the host at the same bit period as the transmit path (1085 clocks/bit). After a sync byte, it writes exactly one frame of bytes into the shared frame RAM through its write port. It flags frame completion and reports framing or timeout errors.

Parameters:
CLKS_PER_BIT, 1085, system clocks per UART bit.
BYTES_PER_FRAME, 9216, bytes written per frame after sync.
ADDR_WIDTH, 15, RAM write address width.
SYNC_BYTE, 8'hAA, byte value that starts a frame load.
TIMEOUT_CLKS, 21700, maximum idle clocks between bytes while loading.

Ports:
i_Clk  input  1  system clock; all logic on the rising edge.
i_Rst  input  1  synchronous, active-high reset.
i_Rx  input  1  asynchronous UART serial line; idles high.
o_Byte_Valid  output  1  one-cycle pulse; o_Byte_Data holds a good byte.
o_Byte_Data  output  8  last received byte.
o_Wr_En  output  1  one-cycle RAM write strobe.
o_Wr_Addr  output  ADDR_WIDTH  RAM write address.
o_Wr_Data  output  8  RAM write data.
o_Frame_Done  output  1  one-cycle pulse after the last frame byte is written.
o_Frame_Error  output  1  sticky error flag; cleared by the next SYNC_BYTE or by reset.
o_Rx_Active  output  1  high while the bit FSM is not in IDLE.

Behaviour:
- Reset (i_Rst high at a clock edge):
  - All outputs go to 0.
  - Synchroniser flops go to 1.
  - Both FSMs return to their initial states; all counters clear.
  - Reset overrides any in-progress byte or frame. A partially received byte is discarded.
- Input synchroniser:
  - i_Rx passes through 2 flops. rx_s is the second flop's output.
  - rx_s alone drives the bit FSM.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE: when rx_s is 0, go to START and clear the clock counter.
  - START: count to (CLKS_PER_BIT-1)/2.
    - rx_s still 0: go to DATA, clear counter and bit index.
    - rx_s is 1: treat as a glitch and return to IDLE; no output.
  - DATA: count to CLKS_PER_BIT-1, then sample rx_s into shift[bit_index], LSB first.
    - After bit 7, go to STOP.
  - STOP: count to CLKS_PER_BIT-1, then sample rx_s.
    - 1: o_Byte_Data <= shift, o_Byte_Valid pulses for 1 cycle.
    - 0: framing error; no valid pulse.
    - Either case: return to IDLE.
  - A continuous low (break) simply restarts START from IDLE.
- Frame FSM states: WAIT_SYNC, LOAD.
  - WAIT_SYNC:
    - Non-sync bytes are ignored, and byte framing errors are ignored.
    - A valid byte equal to SYNC_BYTE moves to LOAD, sets the address counter to 0 and clears o_Frame_Error.
  - LOAD, on each valid byte (the sync value is treated as ordinary data here):
    - One cycle later, o_Wr_En = 1, o_Wr_Addr = the address counter, o_Wr_Data = the byte.
    - The counter increments after the write.
    - Latency from o_Byte_Valid to o_Wr_En is exactly 1 cycle.
  - Frame completion:
    - Completion happens on the write to address BYTES_PER_FRAME-1.
    - o_Frame_Done pulses in the same cycle as that write.
    - The FSM returns to WAIT_SYNC.
    - o_Wr_Addr holds BYTES_PER_FRAME-1 afterwards. No wrap; never exceeds BYTES_PER_FRAME-1.
  - LOAD framing error: set o_Frame_Error, no write, return to WAIT_SYNC.
  - LOAD timeout:
    - The idle counter clears on every o_Byte_Valid and increments otherwise.
    - Reaching TIMEOUT_CLKS sets o_Frame_Error and returns to WAIT_SYNC.
    - RAM contents already written are left as is.
  - Simultaneous events: a timeout and a byte valid in the same cycle → the byte wins; the counter clears and the write proceeds.
- Widths:
  - Clock counter ≥ clog2(CLKS_PER_BIT).
  - Timeout counter ≥ clog2(TIMEOUT_CLKS+1).
  - Address counter is ADDR_WIDTH bits.

Test Plan:
- Bench parameter override: CLKS_PER_BIT=16, BYTES_PER_FRAME=4, TIMEOUT_CLKS=400.
- Send 0x5A, 8N1 → one o_Byte_Valid pulse with o_Byte_Data=0x5A, sampled at mid-bit; no o_Wr_En (still in WAIT_SYNC).
- Send 0xAA,0x01,0x02,0xAA,0xFF → writes (0,0x01),(1,0x02),(2,0xAA),(3,0xFF), each 1 cycle after its valid; o_Frame_Done pulses with the addr-3 write; the next byte causes no write.
- Low glitch of 4 clocks on i_Rx while in IDLE → no o_Byte_Valid; o_Rx_Active returns to 0 at mid-start.
- Sync, 1 data byte, then a byte whose stop bit is 0 → o_Frame_Error=1, no write for the bad byte; the next 0xAA clears o_Frame_Error.
- Sync, 2 bytes, line idle for 400 clocks → o_Frame_Error=1, FSM in WAIT_SYNC, no o_Frame_Done.
- Assert i_Rst mid-DATA during frame loading → all outputs 0 next cycle; a fresh sync plus 4 bytes writes addresses 0..3 correctly.

Source files
------------

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 8N1 UART receiver feeding a frame loader.
// Bytes are deserialised from i_Rx. A SYNC_BYTE arms the loader, which
// then writes the next BYTES_PER_FRAME bytes into the frame RAM write port.
// The loader aborts with a sticky error on a byte framing error or on an
// inter-byte idle gap of TIMEOUT_CLKS clocks.
//
// Ports:
//   i_Clk          system clock, rising edge
//   i_Rst          synchronous active-high reset
//   i_Rx           asynchronous serial line (idles high)
//   o_Byte_Valid   1-cycle pulse, o_Byte_Data holds a good byte
//   o_Byte_Data    last good byte
//   o_Wr_En        1-cycle RAM write strobe
//   o_Wr_Addr      RAM write address
//   o_Wr_Data      RAM write data
//   o_Frame_Done   1-cycle pulse with the last write of a frame
//   o_Frame_Error  sticky error, cleared by next sync byte or reset
//   o_Rx_Active    bit receiver is busy (not IDLE)
module uart_frame_rx #(
    parameter int         CLKS_PER_BIT    = 1085,
    parameter int         BYTES_PER_FRAME = 9216,
    parameter int         ADDR_WIDTH      = 15,
    parameter logic [7:0] SYNC_BYTE       = 8'hAA,
    parameter int         TIMEOUT_CLKS    = 21700
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Rx,
    output logic                  o_Byte_Valid,
    output logic [7:0]            o_Byte_Data,
    output logic                  o_Wr_En,
    output logic [ADDR_WIDTH-1:0] o_Wr_Addr,
    output logic [7:0]            o_Wr_Data,
    output logic                  o_Frame_Done,
    output logic                  o_Frame_Error,
    output logic                  o_Rx_Active
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [CW-1:0]         HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0]         FULL_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]         TO_LIM   = TW'(TIMEOUT_CLKS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BYTES_PER_FRAME - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_state_t;
    typedef enum logic       {WAIT_SYNC, LOAD}          frame_state_t;

    // ------------------------------------------------------------------
    // Input synchroniser (resets to the idle line level)
    // ------------------------------------------------------------------
    logic rx_meta, rx_s;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_Rx;
            rx_s    <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Bit FSM
    // ------------------------------------------------------------------
    bit_state_t    bit_st, bit_nxt;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          cnt_clr, start_ok, bit_sample, byte_ok, byte_bad;
    logic          byte_err;

    always_comb begin
        bit_nxt    = bit_st;
        cnt_clr    = 1'b0;
        start_ok   = 1'b0;
        bit_sample = 1'b0;
        byte_ok    = 1'b0;
        byte_bad   = 1'b0;
        case (bit_st)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rx_s) bit_nxt = START;
            end
            START: begin
                if (clk_cnt == HALF_CNT) begin
                    cnt_clr = 1'b1;
                    // Line back high at mid-start: a glitch, not a byte.
                    if (rx_s) begin
                        bit_nxt = IDLE;
                    end else begin
                        bit_nxt  = DATA;
                        start_ok = 1'b1;
                    end
                end
            end
            DATA: begin
                if (clk_cnt == FULL_CNT) begin
                    cnt_clr    = 1'b1;
                    bit_sample = 1'b1;
                    if (bit_idx == 3'd7) bit_nxt = STOP;
                end
            end
            STOP: begin
                if (clk_cnt == FULL_CNT) begin
                    cnt_clr = 1'b1;
                    bit_nxt = IDLE;
                    if (rx_s) byte_ok  = 1'b1;
                    else      byte_bad = 1'b1;
                end
            end
            default: bit_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            bit_st       <= IDLE;
            clk_cnt      <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            o_Byte_Valid <= 1'b0;
            o_Byte_Data  <= '0;
            byte_err     <= 1'b0;
        end else begin
            bit_st  <= bit_nxt;
            clk_cnt <= cnt_clr ? '0 : clk_cnt + 1'b1;
            if (start_ok)
                bit_idx <= '0;
            else if (bit_sample)
                bit_idx <= bit_idx + 1'b1;
            if (bit_sample)
                shift[bit_idx] <= rx_s;
            o_Byte_Valid <= byte_ok;
            if (byte_ok)
                o_Byte_Data <= shift;
            byte_err <= byte_bad;
        end
    end

    assign o_Rx_Active = (bit_st != IDLE);

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    frame_state_t            fr_st, fr_nxt;
    logic [ADDR_WIDTH-1:0]   addr_cnt;
    logic [TW-1:0]           to_cnt;
    logic                    do_write, last_write, set_err, clr_err;

    always_comb begin
        fr_nxt     = fr_st;
        do_write   = 1'b0;
        last_write = 1'b0;
        set_err    = 1'b0;
        clr_err    = 1'b0;
        case (fr_st)
            WAIT_SYNC: begin
                if (o_Byte_Valid && (o_Byte_Data == SYNC_BYTE)) begin
                    fr_nxt  = LOAD;
                    clr_err = 1'b1;
                end
            end
            LOAD: begin
                // A byte arriving on the timeout cycle takes priority.
                if (o_Byte_Valid) begin
                    do_write = 1'b1;
                    if (addr_cnt == LAST_ADDR) begin
                        last_write = 1'b1;
                        fr_nxt     = WAIT_SYNC;
                    end
                end else if (byte_err || (to_cnt == TO_LIM)) begin
                    set_err = 1'b1;
                    fr_nxt  = WAIT_SYNC;
                end
            end
            default: fr_nxt = WAIT_SYNC;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            fr_st         <= WAIT_SYNC;
            addr_cnt      <= '0;
            to_cnt        <= '0;
            o_Wr_En       <= 1'b0;
            o_Wr_Addr     <= '0;
            o_Wr_Data     <= '0;
            o_Frame_Done  <= 1'b0;
            o_Frame_Error <= 1'b0;
        end else begin
            fr_st <= fr_nxt;

            // Idle gap counter only runs while loading.
            if ((fr_st != LOAD) || o_Byte_Valid)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            if (clr_err)
                addr_cnt <= '0;
            else if (do_write && !last_write)
                addr_cnt <= addr_cnt + 1'b1;

            o_Wr_En      <= do_write;
            o_Frame_Done <= last_write;
            if (do_write) begin
                o_Wr_Addr <= addr_cnt;
                o_Wr_Data <= o_Byte_Data;
            end

            if (clr_err)
                o_Frame_Error <= 1'b0;
            else if (set_err)
                o_Frame_Error <= 1'b1;
        end
    end

endmodule
